tcas_pulse_detector: RTL

Consumes the 24-bit unsigned magnitude stream produced by the CORDIC magnitude stage in the TCAS DMSP chain and detects RF pulses above a threshold. For each qualified pulse it emits one event: leading-edge time of arrival (sample index), width, peak amplitude and a long-pulse flag. Events feed the downstream preamble/reply decoder.

---
 rtl/tcas_dmsp_pkg.sv | 14 +
 rtl/tcas_noise_floor.sv | 48 ++++
 rtl/tcas_pulse_detector.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tcas_dmsp_pkg.sv
// rtl/tcas_dmsp_pkg.sv - shared widths and pulse-detector state encoding for the TCAS DMSP chain
package tcas_dmsp_pkg;

  localparam int MAG_W = 24;
  localparam int TOA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE     = 2'd1,
    HIGH     = 2'd2,
    WAIT_LOW = 2'd3
  } pd_state_t;

endpackage

// File: rtl/tcas_noise_floor.sv
// rtl/tcas_noise_floor.sv - IIR noise-floor tracker and saturating threshold offset
// Built only when TCAS_PULSE_NOISE_TRACK_EN is defined.
module tcas_noise_floor
  import tcas_dmsp_pkg::*;
#(
  parameter int NF_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic [MAG_W-1:0] mag,
  input  logic [MAG_W-1:0] thr_level,
  output logic [MAG_W-1:0] noise_floor,
  output logic [MAG_W-1:0] thr_eff
);

  logic [MAG_W-1:0]        nf;
  logic signed [MAG_W+1:0] diff;
  logic signed [MAG_W+1:0] step;
  logic signed [MAG_W+1:0] sum;
  logic [MAG_W:0]          thr_sum;

  // Two guard bits keep the signed difference and update free of overflow.
  always_comb begin
    diff    = $signed({2'b00, mag}) - $signed({2'b00, nf});
    step    = diff >>> NF_SHIFT;
    sum     = $signed({2'b00, nf}) + step;
    thr_sum = {1'b0, nf} + {1'b0, thr_level};
    thr_eff = thr_sum[MAG_W] ? {MAG_W{1'b1}} : thr_sum[MAG_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nf <= '0;
    end else if (update) begin
      if (sum < 26'sd0) begin
        nf <= '0;
      end else if (sum > 26'sd16777215) begin
        nf <= {MAG_W{1'b1}};
      end else begin
        nf <= sum[MAG_W-1:0];
      end
    end
  end

  assign noise_floor = nf;

endmodule

// File: rtl/tcas_pulse_detector.sv
// rtl/tcas_pulse_detector.sv - threshold pulse detector emitting TOA/width/peak events
// Optional noise-floor tracking under TCAS_PULSE_NOISE_TRACK_EN.
module tcas_pulse_detector
  import tcas_dmsp_pkg::*;
#(
  parameter int MIN_WIDTH = 3,
  parameter int MAX_WIDTH = 64,
  parameter int WIDTH_W   = 8
`ifdef TCAS_PULSE_NOISE_TRACK_EN
  ,
  parameter int NF_SHIFT  = 4
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mag_valid,
  input  logic [23:0]        magnitude,
  input  logic [23:0]        thr_level,
  output logic               above_thr,
  output logic               pulse_valid,
  output logic [31:0]        pulse_toa,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic [23:0]        pulse_peak,
  output logic               pulse_long,
  output logic [23:0]        noise_floor
);

  pd_state_t          state, state_n;
  logic [TOA_W-1:0]   sample_cnt;
  logic               s1_valid;
  logic [MAG_W-1:0]   s1_mag;
  logic [TOA_W-1:0]   s1_idx;
  logic [MAG_W-1:0]   thr_eff;

  logic [TOA_W-1:0]   cur_toa, toa_n;
  logic [WIDTH_W-1:0] cur_width, width_n, width_inc;
  logic [MAG_W-1:0]   cur_peak, peak_n, peak_up;
  logic               ev, ev_long;

`ifdef TCAS_PULSE_NOISE_TRACK_EN
  logic nf_update;
  assign nf_update = s1_valid && (state == IDLE);

  tcas_noise_floor #(
    .NF_SHIFT (NF_SHIFT)
  ) u_noise_floor (
    .clk         (clk),
    .reset       (reset),
    .update      (nf_update),
    .mag         (s1_mag),
    .thr_level   (thr_level),
    .noise_floor (noise_floor),
    .thr_eff     (thr_eff)
  );
`else
  assign noise_floor = '0;
  assign thr_eff     = thr_level;
`endif

  // Stage 1: index stamp and threshold compare; above_thr doubles as the stage-1 flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt <= '0;
      s1_valid   <= 1'b0;
      s1_mag     <= '0;
      s1_idx     <= '0;
      above_thr  <= 1'b0;
    end else begin
      s1_valid <= mag_valid;
      if (mag_valid) begin
        sample_cnt <= sample_cnt + 32'd1;
        s1_mag     <= magnitude;
        s1_idx     <= sample_cnt;
        above_thr  <= magnitude > thr_eff;
      end
    end
  end

  always_comb begin
    state_n   = state;
    toa_n     = cur_toa;
    width_n   = cur_width;
    peak_n    = cur_peak;
    ev        = 1'b0;
    ev_long   = 1'b0;
    width_inc = cur_width + WIDTH_W'(1);
    peak_up   = (s1_mag > cur_peak) ? s1_mag : cur_peak;
    if (s1_valid) begin
      case (state)
        IDLE: begin
          if (above_thr) begin
            toa_n   = s1_idx;
            width_n = WIDTH_W'(1);
            peak_n  = s1_mag;
            state_n = (MIN_WIDTH <= 1) ? HIGH : RISE;
          end
        end
        RISE: begin
          if (above_thr) begin
            width_n = width_inc;
            peak_n  = peak_up;
            if (width_inc == WIDTH_W'(MIN_WIDTH)) state_n = HIGH;
          end else begin
            state_n = IDLE;
          end
        end
        HIGH: begin
          if (above_thr) begin
            width_n = width_inc;
            peak_n  = peak_up;
            if (width_inc == WIDTH_W'(MAX_WIDTH)) begin
              ev      = 1'b1;
              ev_long = 1'b1;
              state_n = WAIT_LOW;
            end
          end else begin
            ev      = 1'b1;
            state_n = IDLE;
          end
        end
        WAIT_LOW: begin
          if (!above_thr) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage 2: pulse tracking registers and held event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_toa     <= '0;
      cur_width   <= '0;
      cur_peak    <= '0;
      pulse_valid <= 1'b0;
      pulse_toa   <= '0;
      pulse_width <= '0;
      pulse_peak  <= '0;
      pulse_long  <= 1'b0;
    end else begin
      state       <= state_n;
      cur_toa     <= toa_n;
      cur_width   <= width_n;
      cur_peak    <= peak_n;
      pulse_valid <= ev;
      if (ev) begin
        pulse_toa   <= toa_n;
        pulse_width <= width_n;
        pulse_peak  <= peak_n;
        pulse_long  <= ev_long;
      end
    end
  end

endmodule
